// File: rtl/pc_inc_pkg.sv
// Shared constants and PC type for the IF-stage next-PC logic.
package pc_inc_pkg;

    localparam int          PC_WIDTH     = 32;
    localparam int unsigned PC_STEP_WORD = 4;
    localparam int unsigned PC_STEP_UNIT = 1;

    typedef logic [PC_WIDTH-1:0] pc_t;

endpackage

// File: rtl/pc_inc_adder.sv
// Combinational pc + STEP with carry-out; STEP is zero-extended to WIDTH+1 bits.
import pc_inc_pkg::*;

module pc_inc_adder #(
    parameter int          WIDTH = PC_WIDTH,
    parameter int unsigned STEP  = PC_STEP_UNIT
) (
    input  logic [WIDTH-1:0] pc_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
);

    localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

    assign {carry_o, sum_o} = {1'b0, pc_i} + STEP_EXT;

endmodule

// File: rtl/pc_incrementer.sv
// Next sequential PC with carry-out and a sticky wrap flag.
// Define PC_INC_REG_OUT_EN to register npc/carry (1-cycle latency, gated by en).
import pc_inc_pkg::*;

module pc_incrementer #(
    parameter int          WIDTH = PC_WIDTH,
    parameter int unsigned STEP  = PC_STEP_UNIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] npc,
    output logic             carry,
    output logic             wrap_seen
);

    logic [WIDTH-1:0] sum;
    logic             sum_c;
    logic             wrap_q, wrap_d;

    pc_inc_adder #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_adder (
        .pc_i    (pc),
        .sum_o   (sum),
        .carry_o (sum_c)
    );

    // Sticky flag follows the combinational carry so it lines up with a registered carry.
    always_comb begin
        wrap_d = wrap_q | (en & sum_c);
    end

    always_ff @(posedge clk) begin
        if (rst) wrap_q <= 1'b0;
        else     wrap_q <= wrap_d;
    end

    assign wrap_seen = wrap_q;

`ifdef PC_INC_REG_OUT_EN
    logic [WIDTH-1:0] npc_q, npc_d;
    logic             carry_q, carry_d;

    always_comb begin
        npc_d   = npc_q;
        carry_d = carry_q;
        if (en) begin
            npc_d   = sum;
            carry_d = sum_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            npc_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            npc_q   <= npc_d;
            carry_q <= carry_d;
        end
    end

    assign npc   = npc_q;
    assign carry = carry_q;
`else
    assign npc   = sum;
    assign carry = sum_c;
`endif

endmodule

// File: tb/tb_pc_incrementer.sv
// Scoreboard bench: STEP=1 and STEP=4 instances share stimulus; a monitor checks each cycle.
import pc_inc_pkg::*;

module tb_pc_incrementer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [31:0] pc  = '0;

    logic [31:0] npc1, npc4;
    logic        carry1, carry4, wrap1, wrap4;

    always #5 clk = ~clk;

    pc_incrementer #(.WIDTH(PC_WIDTH), .STEP(PC_STEP_UNIT)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .pc(pc),
        .npc(npc1), .carry(carry1), .wrap_seen(wrap1)
    );

    pc_incrementer #(.WIDTH(PC_WIDTH), .STEP(PC_STEP_WORD)) u_dut4 (
        .clk(clk), .rst(rst), .en(en), .pc(pc),
        .npc(npc4), .carry(carry4), .wrap_seen(wrap4)
    );

    typedef struct {
        int          idx;
        logic [31:0] n1;
        logic        c1;
        logic        w1;
        logic [31:0] n4;
        logic        c4;
        logic        w4;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   seq    = 0;

    // Reference state: sticky flags and (registered build) held outputs.
    logic        m_w1 = 1'b0, m_w4 = 1'b0;
    logic [31:0] m_n1 = '0,   m_n4 = '0;
    logic        m_c1 = 1'b0, m_c4 = 1'b0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] p, input logic e, input logic r);
        exp_t   x;
        longint s1, s4;
        logic   cy1, cy4;
        @(negedge clk);
        pc  = p;
        en  = e;
        rst = r;
        s1  = longint'({32'h0, p}) + 1;
        s4  = longint'({32'h0, p}) + 4;
        cy1 = (s1 >= 64'h1_0000_0000);
        cy4 = (s4 >= 64'h1_0000_0000);
        s1  = s1 % 64'h1_0000_0000;
        s4  = s4 % 64'h1_0000_0000;
        if (r) begin
            m_w1 = 1'b0;
            m_w4 = 1'b0;
        end else if (e) begin
            if (cy1) m_w1 = 1'b1;
            if (cy4) m_w4 = 1'b1;
        end
`ifdef PC_INC_REG_OUT_EN
        if (r) begin
            m_n1 = '0; m_c1 = 1'b0;
            m_n4 = '0; m_c4 = 1'b0;
        end else if (e) begin
            m_n1 = s1[31:0]; m_c1 = cy1;
            m_n4 = s4[31:0]; m_c4 = cy4;
        end
`else
        m_n1 = s1[31:0]; m_c1 = cy1;
        m_n4 = s4[31:0]; m_c4 = cy4;
`endif
        x.idx = seq++;
        x.n1 = m_n1; x.c1 = m_c1; x.w1 = m_w1;
        x.n4 = m_n4; x.c4 = m_c4; x.w4 = m_w4;
        q.push_back(x);
    endtask

    // Monitor: every expectation is consumed just after the edge following its drive.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                x = q.pop_front();
                chk("npc1",   x.idx, npc1,          x.n1);
                chk("carry1", x.idx, {31'b0, carry1}, {31'b0, x.c1});
                chk("wrap1",  x.idx, {31'b0, wrap1},  {31'b0, x.w1});
                chk("npc4",   x.idx, npc4,          x.n4);
                chk("carry4", x.idx, {31'b0, carry4}, {31'b0, x.c4});
                chk("wrap4",  x.idx, {31'b0, wrap4},  {31'b0, x.w4});
            end
        end
    end

    initial begin
        logic [31:0] p;
        drive(32'h0000_0000, 1'b1, 1'b1);
        drive(32'h0000_0000, 1'b1, 1'b1);
        drive(32'h0000_0000, 1'b1, 1'b0);
        drive(32'h0000_0001, 1'b1, 1'b0);
        drive(32'h0000_FFFF, 1'b1, 1'b0);
        drive(32'h0040_0000, 1'b1, 1'b0);
        drive(32'hFFFF_FFFC, 1'b1, 1'b0);
        drive(32'hFFFF_FFFF, 1'b1, 1'b0);
        drive(32'h0000_0000, 1'b1, 1'b0);
        drive(32'hFFFF_FFFF, 1'b1, 1'b1);
        drive(32'hFFFF_FFFF, 1'b1, 1'b0);
        drive(32'h0000_0000, 1'b1, 1'b1);
        drive(32'hFFFF_FFFF, 1'b0, 1'b0);
        drive(32'h0000_0005, 1'b1, 1'b0);
        drive(32'h0000_0009, 1'b0, 1'b0);
        drive(32'h0000_0009, 1'b0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) p = 32'hFFFF_FFFF - $urandom_range(0, 7);
            else                           p = $urandom;
            drive(p, ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
        end
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
